// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: word width, the canonical bubble instruction
// and the IF/ID bundle seen by decode and the hazard unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            fault;
    logic            misaligned;
  } if_id_t;

  // A bubble still carries the current pc so downstream debug traces stay readable.
  function automatic if_id_t make_bubble(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] pc_plus4,
                                         input logic [XLEN-1:0] nop);
    if_id_t b;
    b.valid      = 1'b0;
    b.pc         = pc;
    b.pc_plus4   = pc_plus4;
    b.instr      = nop;
    b.fault      = 1'b0;
    b.misaligned = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with next-PC selection: redirect beats stall, otherwise
// sequential increment that wraps modulo 2^32.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  // Flush does not disturb PC flow, so it does not appear here.
  always_comb begin
    pc_d = pc_plus4_o;
    if (redirect_valid_i) begin
      pc_d = redirect_target_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: drives the PC to instruction memory, captures the returned word
// into IF/ID and counts accepted fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_fault,
  output logic        if_id_misaligned,
  output logic [31:0] fetch_count
);

  import riscv_pkg::*;

  // Highest pc whose full word fits; comparing against this avoids pc+3 overflow.
  localparam logic [XLEN-1:0] LAST_WORD_PC = XLEN'(IMEM_BYTES - 4);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            out_of_range;
  if_id_t          if_id_q;
  if_id_t          if_id_d;
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] fetch_count_d;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .pc_o             (pc),
    .pc_plus4_o       (pc_plus4)
  );

  assign imem_addr    = pc;
  assign out_of_range = (pc > LAST_WORD_PC);

  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      if_id_d = make_bubble(pc, pc_plus4, NOP_INSTR);
    end else if (!stall) begin
      if (flush) begin
        if_id_d = make_bubble(pc, pc_plus4, NOP_INSTR);
      end else begin
        if_id_d.valid      = 1'b1;
        if_id_d.pc         = pc;
        if_id_d.pc_plus4   = pc_plus4;
        if_id_d.instr      = out_of_range ? NOP_INSTR : imem_instr;
        if_id_d.fault      = out_of_range;
        if_id_d.misaligned = |pc[1:0];
        fetch_count_d      = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q       <= make_bubble('0, '0, NOP_INSTR);
      fetch_count_q <= '0;
    end else begin
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_id_valid      = if_id_q.valid;
  assign if_id_pc         = if_id_q.pc;
  assign if_id_pc_plus4   = if_id_q.pc_plus4;
  assign if_id_instr      = if_id_q.instr;
  assign if_id_fault      = if_id_q.fault;
  assign if_id_misaligned = if_id_q.misaligned;
  assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a little-endian byte memory model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_fault;
  logic        if_id_misaligned;
  logic [31:0] fetch_count;

  logic [7:0]  mem [0:1023];
  int          totalChecks = 0;
  int          badChecks   = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(1024),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .if_id_fault     (if_id_fault),
    .if_id_misaligned(if_id_misaligned),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beyond the array the memory returns garbage that must never reach IF/ID.
  always @* begin
    if (imem_addr <= 32'd1020) begin
      imem_instr = {mem[imem_addr[9:0] + 10'd3], mem[imem_addr[9:0] + 10'd2],
                    mem[imem_addr[9:0] + 10'd1], mem[imem_addr[9:0]]};
    end else begin
      imem_instr = 32'hBAD0_BAD0;
    end
  end

  task automatic putWord(input int addr, input logic [31:0] w);
    mem[addr]     = w[7:0];
    mem[addr + 1] = w[15:8];
    mem[addr + 2] = w[23:16];
    mem[addr + 3] = w[31:24];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic rv, input logic [31:0] rt);
    rst             = r;
    stall           = st;
    flush           = fl;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a += 4) putWord(a, 32'hA000_0000 | a);
    putWord(0, 32'h0062_8433);
    putWord(4, 32'h0084_2483);

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_addr",  imem_addr, 32'h0);
    checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("rst_pc",    if_id_pc, 32'h0);
    checkOutput("rst_pc4",   if_id_pc_plus4, 32'h0);
    checkOutput("rst_instr", if_id_instr, 32'h13);
    checkOutput("rst_flags", {30'b0, if_id_fault, if_id_misaligned}, 32'h0);
    checkOutput("rst_count", fetch_count, 32'h0);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run1_pc",    if_id_pc, 32'h0);
    checkOutput("run1_instr", if_id_instr, 32'h0062_8433);
    checkOutput("run1_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("run1_pc4",   if_id_pc_plus4, 32'h4);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run2_pc",    if_id_pc, 32'h4);
    checkOutput("run2_instr", if_id_instr, 32'h0084_2483);
    checkOutput("run2_count", fetch_count, 32'd2);
    checkOutput("run2_addr",  imem_addr, 32'h8);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("stall_addr",  imem_addr, 32'h8);
      checkOutput("stall_pc",    if_id_pc, 32'h4);
      checkOutput("stall_instr", if_id_instr, 32'h0084_2483);
      checkOutput("stall_count", fetch_count, 32'd2);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rel_pc",    if_id_pc, 32'h8);
    checkOutput("rel_instr", if_id_instr, 32'hA000_0008);
    checkOutput("rel_count", fetch_count, 32'd3);

    applyStimulus(0, 1, 0, 1, 32'h40);
    checkOutput("redir_addr",  imem_addr, 32'h40);
    checkOutput("redir_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("redir_instr", if_id_instr, 32'h13);
    checkOutput("redir_count", fetch_count, 32'd3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tgt_pc",    if_id_pc, 32'h40);
    checkOutput("tgt_instr", if_id_instr, 32'hA000_0040);
    checkOutput("tgt_count", fetch_count, 32'd4);

    applyStimulus(0, 0, 0, 1, 32'h3FE);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("edge_flags", {30'b0, if_id_fault, if_id_misaligned}, 32'h3);
    checkOutput("edge_instr", if_id_instr, 32'h13);
    checkOutput("edge_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("edge_addr",  imem_addr, 32'h402);
    checkOutput("edge_count", fetch_count, 32'd5);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("oor_flags", {30'b0, if_id_fault, if_id_misaligned}, 32'h3);
    checkOutput("oor_count", fetch_count, 32'd6);

    applyStimulus(0, 0, 0, 1, 32'h3FC);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("last_flags", {30'b0, if_id_fault, if_id_misaligned}, 32'h0);
    checkOutput("last_instr", if_id_instr, 32'hA000_03FC);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("past_flags", {30'b0, if_id_fault, if_id_misaligned}, 32'h2);
    checkOutput("past_instr", if_id_instr, 32'h13);
    checkOutput("past_count", fetch_count, 32'd8);

    applyStimulus(0, 0, 0, 1, 32'h10);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("flush_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("flush_instr", if_id_instr, 32'h13);
    checkOutput("flush_addr",  imem_addr, 32'h14);
    checkOutput("flush_count", fetch_count, 32'd8);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("postfl_pc",    if_id_pc, 32'h14);
    checkOutput("postfl_count", fetch_count, 32'd9);

    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_pc",    if_id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4",   if_id_pc_plus4, 32'h0);
    checkOutput("wrap_addr",  imem_addr, 32'h0);
    checkOutput("wrap_fault", {31'b0, if_id_fault}, 32'h1);
    checkOutput("wrap_count", fetch_count, 32'd10);

    applyStimulus(0, 0, 0, 1, 32'h0);
    checkOutput("self_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("self_addr",  imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("self_pc",    if_id_pc, 32'h0);
    checkOutput("self_instr", if_id_instr, 32'h0062_8433);
    checkOutput("self_count", fetch_count, 32'd11);

    applyStimulus(0, 0, 0, 1, 32'h20);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_pc",    if_id_pc, 32'h20);
    checkOutput("mid_count", fetch_count, 32'd12);
    applyStimulus(1, 1, 0, 1, 32'h80);
    checkOutput("mrst_addr",  imem_addr, 32'h0);
    checkOutput("mrst_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("mrst_pc",    if_id_pc, 32'h0);
    checkOutput("mrst_pc4",   if_id_pc_plus4, 32'h0);
    checkOutput("mrst_instr", if_id_instr, 32'h13);
    checkOutput("mrst_flags", {30'b0, if_id_fault, if_id_misaligned}, 32'h0);
    checkOutput("mrst_count", fetch_count, 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
